trisc3_mc: RTL and testbench

Parametrised multi-cycle T-RISC core executing the same 32-bit Nios-II-style instruction subset as the single-cycle T-RISC machine. It uses a rising-edge-only FSM in place of the mixed-edge single-cycle datapath. Instruction and data memories are external behind req/ack handshakes, so wait-state RAMs are supported. It also provides NIO byte-wide I/O ports in place of a single port. It is the CPU top of the next-generation FPGA test design.

---
 rtl/trisc3_mc.sv | 220 ++++++++++++++++++++++
 tb/tb_trisc3_mc.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trisc3_mc.sv
// trisc3_mc: multi-cycle T-RISC core (Nios-II subset) with req/ack instruction and data
// memories and NIO byte-wide I/O ports mapped at or above IO_BASE.
module trisc3_mc #(
    parameter int unsigned AW      = 14,
    parameter int unsigned IO_BASE = 16384,
    parameter int unsigned NIO     = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic                 imem_req,
    output logic [AW-3:0]        imem_addr,
    input  logic [31:0]          imem_rdata,
    input  logic                 imem_ack,
    output logic                 dmem_req,
    output logic                 dmem_we,
    output logic [AW-3:0]        dmem_addr,
    output logic [31:0]          dmem_wdata,
    input  logic [31:0]          dmem_rdata,
    input  logic                 dmem_ack,
    input  logic [8*NIO-1:0]     in_port,
    output logic [8*NIO-1:0]     out_port,
    output logic                 illegal
);
    localparam int unsigned PW = (NIO > 1) ? $clog2(NIO) : 1;
    localparam int unsigned SW = PW + 3;

    localparam logic [5:0] OP_CALL = 6'h00, OP_JMPI = 6'h01, OP_ADDI = 6'h04, OP_BR    = 6'h06;
    localparam logic [5:0] OP_ANDI = 6'h0C, OP_ORI  = 6'h14, OP_STW  = 6'h15, OP_LDW   = 6'h17;
    localparam logic [5:0] OP_XORI = 6'h1C, OP_BNE  = 6'h1E, OP_BEQ  = 6'h26, OP_ORHI  = 6'h34;
    localparam logic [5:0] OP_STWIO = 6'h35, OP_LDWIO = 6'h37, OP_RTYPE = 6'h3A;
    localparam logic [5:0] X_RET = 6'h05, X_JMP = 6'h0D, X_AND = 6'h0E, X_OR = 6'h16;
    localparam logic [5:0] X_XOR = 6'h1E, X_ADD = 6'h31, X_SUB = 6'h39;

    typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM} state_t;

    function automatic logic f_legal(input logic [31:0] ir);
        logic ok;
        ok = 1'b0;
        case (ir[5:0])
            OP_CALL, OP_JMPI, OP_ADDI, OP_BR, OP_ANDI, OP_ORI, OP_STW, OP_LDW,
            OP_XORI, OP_BNE, OP_BEQ, OP_ORHI, OP_STWIO, OP_LDWIO: ok = 1'b1;
            OP_RTYPE: begin
                case (ir[16:11])
                    X_RET, X_JMP, X_AND, X_OR, X_XOR, X_ADD, X_SUB: ok = 1'b1;
                    default: ok = 1'b0;
                endcase
            end
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    state_t         r_state, w_state_nxt;
    logic [AW-1:0]  r_pc, w_pc_nxt, w_pc4, w_btgt, w_jtgt;
    logic [31:0]    r_ir;
    logic [31:0]    r_rf [32];
    logic [8*NIO-1:0] r_out;
    logic           r_imem_req, r_dmem_req, r_dmem_we, r_illegal;
    logic [AW-3:0]  r_dmem_addr;
    logic [31:0]    r_dmem_wdata;

    logic [5:0]     w_op, w_opx;
    logic [4:0]     w_a, w_b, w_c, w_rf_wa;
    logic [15:0]    w_imm16;
    logic [31:0]    w_imm32, w_ra, w_rb, w_dma, w_rf_wd;
    logic           w_io, w_rf_we, w_out_we, w_ir_ld, w_mem_ld, w_mem_st;
    logic [29:0]    w_pofs;
    logic [PW-1:0]  w_pidx;
    logic [SW-1:0]  w_psel;
    logic [7:0]     w_in_byte;

    // Instruction field decode and operand fetch
    assign w_op      = r_ir[5:0];
    assign w_a       = r_ir[31:27];
    assign w_b       = r_ir[26:22];
    assign w_c       = r_ir[21:17];
    assign w_opx     = r_ir[16:11];
    assign w_imm16   = r_ir[21:6];
    assign w_imm32   = (w_op == OP_ORHI) ? {w_imm16, 16'h0000} : {{16{w_imm16[15]}}, w_imm16};
    assign w_ra      = r_rf[w_a];
    assign w_rb      = r_rf[w_b];
    assign w_pc4     = r_pc + AW'(4);
    assign w_btgt    = w_pc4 + w_imm32[AW-1:0];
    assign w_jtgt    = {r_ir[AW+3:6], 2'b00};
    assign w_dma     = w_ra + w_imm32;
    assign w_io      = (w_dma >= 32'(IO_BASE));
    assign w_pofs    = w_dma[31:2] - 30'(IO_BASE / 4);
    assign w_pidx    = PW'(w_pofs % 30'(NIO));
    assign w_psel    = {w_pidx, 3'b000};
    assign w_in_byte = in_port[w_psel +: 8];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_FETCH;
        else        r_state <= w_state_nxt;
    end

    // Next state, pc, register-file and port write control
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_rf_we     = 1'b0;
        w_rf_wa     = w_b;
        w_rf_wd     = '0;
        w_out_we    = 1'b0;
        w_ir_ld     = 1'b0;
        w_mem_ld    = 1'b0;
        w_mem_st    = 1'b0;
        case (r_state)
            S_FETCH: begin
                if (imem_ack) begin
                    w_ir_ld     = 1'b1;
                    w_state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                w_state_nxt = S_FETCH;
                w_pc_nxt    = w_pc4;
                case (w_op)
                    OP_CALL: begin
                        w_pc_nxt = w_jtgt;
                        w_rf_we  = 1'b1;
                        w_rf_wa  = 5'd31;
                        w_rf_wd  = 32'(w_pc4);
                    end
                    OP_JMPI: w_pc_nxt = w_jtgt;
                    OP_ADDI: begin w_rf_we = 1'b1; w_rf_wd = w_ra + w_imm32; end
                    OP_ANDI: begin w_rf_we = 1'b1; w_rf_wd = w_ra & w_imm32; end
                    OP_ORI, OP_ORHI: begin w_rf_we = 1'b1; w_rf_wd = w_ra | w_imm32; end
                    OP_XORI: begin w_rf_we = 1'b1; w_rf_wd = w_ra ^ w_imm32; end
                    OP_BR:   w_pc_nxt = w_btgt;
                    OP_BEQ:  if (w_ra == w_rb) w_pc_nxt = w_btgt;
                    OP_BNE:  if (w_ra != w_rb) w_pc_nxt = w_btgt;
                    OP_STW, OP_STWIO: begin
                        if (w_io) begin
                            w_out_we = 1'b1;
                        end else begin
                            w_state_nxt = S_MEM;
                            w_pc_nxt    = r_pc;
                            w_mem_ld    = 1'b1;
                            w_mem_st    = 1'b1;
                        end
                    end
                    OP_LDW, OP_LDWIO: begin
                        if (w_io) begin
                            w_rf_we = 1'b1;
                            w_rf_wd = {24'h0, w_in_byte};
                        end else begin
                            w_state_nxt = S_MEM;
                            w_pc_nxt    = r_pc;
                            w_mem_ld    = 1'b1;
                        end
                    end
                    OP_RTYPE: begin
                        w_rf_wa = w_c;
                        case (w_opx)
                            X_RET: w_pc_nxt = {r_rf[31][AW-1:2], 2'b00};
                            X_JMP: w_pc_nxt = {w_ra[AW-1:2], 2'b00};
                            X_AND: begin w_rf_we = 1'b1; w_rf_wd = w_ra & w_rb; end
                            X_OR:  begin w_rf_we = 1'b1; w_rf_wd = w_ra | w_rb; end
                            X_XOR: begin w_rf_we = 1'b1; w_rf_wd = w_ra ^ w_rb; end
                            X_ADD: begin w_rf_we = 1'b1; w_rf_wd = w_ra + w_rb; end
                            X_SUB: begin w_rf_we = 1'b1; w_rf_wd = w_ra - w_rb; end
                            default: ;
                        endcase
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                if (dmem_ack) begin
                    w_state_nxt = S_FETCH;
                    w_pc_nxt    = w_pc4;
                    if (!r_dmem_we) begin
                        w_rf_we = 1'b1;
                        w_rf_wd = dmem_rdata;
                    end
                end
            end
            default: w_state_nxt = S_FETCH;
        endcase
    end

    // Datapath registers; r0 is never written so it always reads zero
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc         <= '0;
            r_ir         <= '0;
            r_out        <= '0;
            r_imem_req   <= 1'b1;
            r_dmem_req   <= 1'b0;
            r_dmem_we    <= 1'b0;
            r_dmem_addr  <= '0;
            r_dmem_wdata <= '0;
            r_illegal    <= 1'b0;
            for (int i = 0; i < 32; i++) r_rf[i] <= '0;
        end else begin
            r_pc       <= w_pc_nxt;
            r_imem_req <= (w_state_nxt == S_FETCH);
            r_dmem_req <= (w_state_nxt == S_MEM);
            r_illegal  <= w_ir_ld && !f_legal(imem_rdata);
            if (w_ir_ld) r_ir <= imem_rdata;
            if (w_rf_we && (w_rf_wa != 5'd0)) r_rf[w_rf_wa] <= w_rf_wd;
            if (w_out_we) r_out[w_psel +: 8] <= w_rb[7:0];
            if (w_mem_ld) begin
                r_dmem_we    <= w_mem_st;
                r_dmem_addr  <= w_dma[AW-1:2];
                r_dmem_wdata <= w_rb;
            end
        end
    end

    assign imem_req   = r_imem_req;
    assign imem_addr  = r_pc[AW-1:2];
    assign dmem_req   = r_dmem_req;
    assign dmem_we    = r_dmem_we;
    assign dmem_addr  = r_dmem_addr;
    assign dmem_wdata = r_dmem_wdata;
    assign out_port   = r_out;
    assign illegal    = r_illegal;
endmodule

// File: tb/tb_trisc3_mc.sv
// Self-checking bench for trisc3_mc: ALU vector table run as tiny programs, plus directed
// sequences for fetch cadence, branches, wait-state memory, call/ret/jumps, I/O, illegal ops, reset.
module tb_trisc3_mc;
    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req, imem_ack;
    logic [11:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [11:0] dmem_addr;
    logic [31:0] dmem_wdata, dmem_rdata;
    logic [31:0] in_port, out_port;
    logic        illegal;

    trisc3_mc #(.AW(14), .IO_BASE(16384), .NIO(4)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ack(imem_ack),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .in_port(in_port), .out_port(out_port), .illegal(illegal)
    );

    always #5 clk = ~clk;

    logic [31:0] imem [4096];
    logic [31:0] dmem [4096];
    int          imem_wait = 0, dmem_wait = 0, icnt = 0, dcnt = 0;
    bit          dmem_force = 1'b0;
    logic [11:0] flog[$];
    int          dreq_runs[$];
    int          drun = 0, dunstable = 0, ill_cycles = 0, st_cnt = 0;
    logic [11:0] daddr0;
    logic [31:0] dwd0, st_wdata;
    int          n_checks = 0, n_fail = 0;

    function automatic logic [31:0] ity(input logic [5:0] op, input logic [4:0] a,
                                        input logic [4:0] b, input logic [15:0] imm);
        return {a, b, imm, op};
    endfunction
    function automatic logic [31:0] rty(input logic [5:0] opx, input logic [4:0] a,
                                        input logic [4:0] b, input logic [4:0] c);
        return {a, b, c, opx, 5'd0, 6'h3A};
    endfunction

    localparam logic [31:0] NOP  = 32'h0000_0004;
    localparam logic [31:0] HALT = 32'h003F_FF06;

    // Instruction memory with programmable wait states
    always @(negedge clk) begin
        if (imem_req) begin
            icnt++;
            if (icnt > imem_wait) begin imem_ack = 1'b1; imem_rdata = imem[imem_addr]; end
            else begin imem_ack = 1'b0; imem_rdata = 32'hFFFF_FFFF; end
        end else begin
            icnt = 0; imem_ack = 1'b0;
        end
    end

    // Data memory with programmable wait states and a forced-ack mode
    always @(negedge clk) begin
        if (dmem_force) begin
            dcnt = 0; dmem_ack = 1'b1;
        end else if (dmem_req) begin
            dcnt++;
            if (dcnt > dmem_wait) begin
                dmem_ack = 1'b1;
                dmem_rdata = dmem[dmem_addr];
                if (dmem_we) begin dmem[dmem_addr] = dmem_wdata; st_wdata = dmem_wdata; st_cnt++; end
            end else dmem_ack = 1'b0;
        end else begin
            dcnt = 0; dmem_ack = 1'b0;
        end
    end

    always @(posedge clk) if (reset && imem_req && imem_ack) flog.push_back(imem_addr);

    always @(negedge clk) begin
        if (reset && dmem_req) begin
            if (drun == 0) begin daddr0 = dmem_addr; dwd0 = dmem_wdata; end
            else if (dmem_addr != daddr0 || dmem_wdata != dwd0) dunstable++;
            drun++;
        end else if (drun != 0) begin
            dreq_runs.push_back(drun); drun = 0;
        end
        if (illegal) ill_cycles++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] flog_at(input int i);
        return (i < flog.size()) ? 32'(flog[i]) : 32'hFFFF_FFFF;
    endfunction
    function automatic logic [31:0] run_at(input int i);
        return (i < dreq_runs.size()) ? 32'(dreq_runs[i]) : 32'hFFFF_FFFF;
    endfunction

    task automatic load_default();
        for (int i = 0; i < 4096; i++) begin imem[i] = HALT; dmem[i] = 32'h0; end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        flog.delete(); dreq_runs.delete();
        drun = 0; dunstable = 0; ill_cycles = 0; st_cnt = 0;
        reset = 1'b1;
    endtask

    task automatic run(input int n);
        repeat (n) @(negedge clk);
    endtask

    typedef struct {
        string       name;
        logic [15:0] a16;
        logic [15:0] b16;
        logic [31:0] instr;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[13];

    initial begin
        reset = 1'b0; imem_ack = 1'b0; imem_rdata = '0; dmem_ack = 1'b0; dmem_rdata = '0;
        in_port = 32'h0;
        vecs[0]  = '{"add",      16'h0005, 16'hFFFD, rty(6'h31, 5'd1, 5'd2, 5'd3), 32'h0000_0002};
        vecs[1]  = '{"sub",      16'h0005, 16'h0007, rty(6'h39, 5'd1, 5'd2, 5'd3), 32'hFFFF_FFFE};
        vecs[2]  = '{"sub_rev",  16'h0005, 16'h0007, rty(6'h39, 5'd2, 5'd1, 5'd3), 32'h0000_0002};
        vecs[3]  = '{"and",      16'h00F0, 16'h0FF0, rty(6'h0E, 5'd1, 5'd2, 5'd3), 32'h0000_00F0};
        vecs[4]  = '{"or",       16'h8000, 16'h0001, rty(6'h16, 5'd1, 5'd2, 5'd3), 32'hFFFF_8001};
        vecs[5]  = '{"xor",      16'h1234, 16'h00FF, rty(6'h1E, 5'd1, 5'd2, 5'd3), 32'h0000_12CB};
        vecs[6]  = '{"add_wrap", 16'h8000, 16'h8000, rty(6'h31, 5'd1, 5'd2, 5'd3), 32'hFFFF_0000};
        vecs[7]  = '{"add_r0",   16'h0005, 16'h0003, rty(6'h31, 5'd1, 5'd2, 5'd0), 32'h0000_0000};
        vecs[8]  = '{"addi",     16'h0001, 16'h0000, ity(6'h04, 5'd1, 5'd3, 16'h7FFF), 32'h0000_8000};
        vecs[9]  = '{"andi",     16'hFFFF, 16'h0000, ity(6'h0C, 5'd1, 5'd3, 16'h8001), 32'hFFFF_8001};
        vecs[10] = '{"ori",      16'h000F, 16'h0000, ity(6'h14, 5'd1, 5'd3, 16'h00F0), 32'h0000_00FF};
        vecs[11] = '{"xori",     16'h0001, 16'h0000, ity(6'h1C, 5'd1, 5'd3, 16'hFFFF), 32'hFFFF_FFFE};
        vecs[12] = '{"orhi",     16'h0012, 16'h0000, ity(6'h34, 5'd1, 5'd3, 16'hABCD), 32'hABCD_0012};

        // Reset values and fetch cadence with zero-wait instruction memory
        load_default();
        for (int i = 0; i < 16; i++) imem[i] = NOP;
        reset = 1'b0;
        run(3);
        chk("rst_imem_req", 32'(imem_req), 32'h1);
        chk("rst_dmem_req", 32'(dmem_req), 32'h0);
        chk("rst_dmem_we", 32'(dmem_we), 32'h0);
        chk("rst_illegal", 32'(illegal), 32'h0);
        chk("rst_out_port", out_port, 32'h0);
        chk("rst_imem_addr", 32'(imem_addr), 32'h0);
        chk("rst_dmem_addr", 32'(dmem_addr), 32'h0);
        chk("rst_dmem_wdata", dmem_wdata, 32'h0);
        do_reset();
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            chk($sformatf("cadence_addr_%0d", k), 32'(imem_addr), 32'(k / 2));
            chk($sformatf("cadence_req_%0d", k), 32'(imem_req), 32'(k % 2 == 0));
        end
        chk("cadence_out_port", out_port, 32'h0);
        chk("cadence_illegal", 32'(ill_cycles), 32'h0);

        // ALU vector table: each vector runs addi r1; addi r2; op; stw r3,0x80(r0)
        foreach (vecs[v]) begin
            load_default();
            imem[0] = ity(6'h04, 5'd0, 5'd1, vecs[v].a16);
            imem[1] = ity(6'h04, 5'd0, 5'd2, vecs[v].b16);
            imem[2] = vecs[v].instr;
            imem[3] = ity(6'h15, 5'd0, 5'd3, 16'h0080);
            dmem[32] = 32'hDEAD_BEEF;
            do_reset();
            run(30);
            chk({"vec_", vecs[v].name}, dmem[32], vecs[v].exp);
        end

        // addi/addi/add/stwio: port 0 updates exactly two cycles after the stwio fetch ack
        load_default();
        imem[0] = ity(6'h04, 5'd0, 5'd1, 16'h0005);
        imem[1] = ity(6'h04, 5'd0, 5'd2, 16'hFFFD);
        imem[2] = rty(6'h31, 5'd1, 5'd2, 5'd3);
        imem[3] = ity(6'h35, 5'd0, 5'd3, 16'h4000);
        do_reset();
        run(7);
        chk("stwio_before", out_port, 32'h0);
        run(1);
        chk("stwio_after", out_port, 32'h0000_0002);
        run(10);
        chk("stwio_hold", out_port, 32'h0000_0002);

        // beq taken at 0x20 with one imem wait state
        imem_wait = 1;
        load_default();
        imem[0] = ity(6'h04, 5'd0, 5'd1, 16'h0005);
        for (int i = 1; i < 8; i++) imem[i] = NOP;
        imem[8] = ity(6'h26, 5'd1, 5'd1, 16'h0008);
        do_reset();
        run(60);
        chk("beq_from", flog_at(8), 32'h8);
        chk("beq_target", flog_at(9), 32'hB);

        // bne not taken at 0x20, then bne r1,r0 taken at 0x24
        imem[8] = ity(6'h1E, 5'd1, 5'd1, 16'h0008);
        imem[9] = ity(6'h1E, 5'd1, 5'd0, 16'h0008);
        do_reset();
        run(60);
        chk("bne_fall", flog_at(9), 32'h9);
        chk("bne_taken", flog_at(10), 32'hC);
        imem_wait = 0;

        // stw/ldw through dmem with three wait cycles each
        dmem_wait = 3;
        load_default();
        imem[0] = ity(6'h04, 5'd0, 5'd1, 16'h0005);
        imem[1] = ity(6'h15, 5'd0, 5'd1, 16'h0040);
        imem[2] = ity(6'h17, 5'd0, 5'd4, 16'h0040);
        imem[3] = ity(6'h35, 5'd0, 5'd4, 16'h4000);
        do_reset();
        run(40);
        chk("mem_st_req_len", run_at(0), 32'd4);
        chk("mem_ld_req_len", run_at(1), 32'd4);
        chk("mem_addr", 32'(daddr0), 32'h10);
        chk("mem_stable", 32'(dunstable), 32'h0);
        chk("mem_store_cnt", 32'(st_cnt), 32'h1);
        chk("mem_wdata", st_wdata, 32'h5);
        chk("mem_dmem", dmem[16], 32'h5);
        chk("mem_ldw_r4", out_port, 32'h0000_0005);
        dmem_wait = 0;

        // call/ret, ldwio from port 2, port index wrap, jmpi and jmp with unaligned rA
        load_default();
        in_port = 32'h11A5_2233;
        for (int i = 0; i < 4; i++) imem[i] = NOP;
        imem[4]    = {26'h40, 6'h00};
        imem[64]   = rty(6'h05, 5'd31, 5'd0, 5'd0);
        imem[5]    = ity(6'h35, 5'd0, 5'd31, 16'h4004);
        imem[6]    = ity(6'h37, 5'd0, 5'd5, 16'h4008);
        imem[7]    = ity(6'h35, 5'd0, 5'd5, 16'h400C);
        imem[8]    = ity(6'h15, 5'd0, 5'd5, 16'h0084);
        imem[9]    = ity(6'h35, 5'd0, 5'd31, 16'h4018);
        imem[10]   = {26'h80, 6'h01};
        imem[128]  = ity(6'h04, 5'd0, 5'd6, 16'h0303);
        imem[129]  = rty(6'h0D, 5'd6, 5'd0, 5'd0);
        dmem[33]   = 32'hFFFF_FFFF;
        do_reset();
        run(60);
        chk("call_target", flog_at(5), 32'h40);
        chk("ret_target", flog_at(6), 32'h5);
        chk("jmpi_target", flog_at(12), 32'h80);
        chk("jmp_target", flog_at(14), 32'hC0);
        chk("io_ports", out_port, 32'hA514_1400);
        chk("ldwio_r5", dmem[33], 32'h0000_00A5);
        in_port = 32'h0;

        // Illegal opcode and illegal R-type opx: one pulse each, no register write
        load_default();
        imem[0] = ity(6'h04, 5'd0, 5'd1, 16'h0007);
        imem[1] = ity(6'h3F, 5'd1, 5'd1, 16'h0001);
        imem[2] = rty(6'h3F, 5'd1, 5'd1, 5'd1);
        imem[3] = ity(6'h35, 5'd0, 5'd1, 16'h4000);
        do_reset();
        run(30);
        chk("illegal_cycles", 32'(ill_cycles), 32'd2);
        chk("illegal_pc4", flog_at(2), 32'h2);
        chk("illegal_pc4_x", flog_at(3), 32'h3);
        chk("illegal_nowrite", out_port, 32'h0000_0007);

        // Reset asserted mid-MEM with the load ack still pending
        dmem_wait = 10;
        load_default();
        imem[0] = ity(6'h17, 5'd0, 5'd1, 16'h0040);
        do_reset();
        for (int i = 0; i < 20 && !dmem_req; i++) @(negedge clk);
        chk("rstmem_req_seen", 32'(dmem_req), 32'h1);
        run(2);
        reset = 1'b0;
        #1;
        chk("rstmem_dmem_req", 32'(dmem_req), 32'h0);
        chk("rstmem_imem_req", 32'(imem_req), 32'h1);
        dmem_force = 1'b1;
        @(negedge clk);
        flog.delete();
        reset = 1'b1;
        @(negedge clk);
        chk("rstmem_pc", 32'(imem_addr), 32'h0);
        chk("rstmem_no_mem", 32'(dmem_req), 32'h0);
        @(negedge clk);
        chk("rstmem_reissue", 32'(dmem_req), 32'h1);
        chk("rstmem_fetch0", flog_at(0), 32'h0);
        dmem_force = 1'b0;
        dmem_wait = 0;
        run(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
